conv_out_seq: RTL and testbench
===============================

CONV_OUT_SEQ -- requirements
Module: conv_out_seq

Interface
REQ-001 Parameter N_TAPS, default 25, MAC cycles per output neuron (in_ch/4+1)*5*5; legal 1..255.
REQ-002 Parameter PLANE_SIZE, default 196, output neurons per plane (R*C); legal 1..65535.
REQ-003 Parameter N_PLANES, default 6, output planes per layer; legal 1..255.
REQ-004 Parameter AW, default 16, write-address width; elaboration SHALL fail if N_PLANES*PLANE_SIZE > 2**AW.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 start  in  1  pulse; begins one layer pass; ignored while busy=1.
REQ-008 abort  in  1  synchronous; terminates the pass.
REQ-009 mac_valid  in  1  datapath presents one tap product this cycle.
REQ-010 wr_ready  in  1  output memory accepts the write this cycle.
REQ-011 mac_en  out  1  datapath may consume a tap (high in ACCUM only).
REQ-012 acc_clr  out  1  accumulator clears/loads with the first tap of a neuron.
REQ-013 neuron_rdy  out  1  one-cycle pulse; last tap of a neuron consumed.
REQ-014 wr_en  out  1  write request, held until accepted.
REQ-015 wr_addr  out  AW  output address = plane*PLANE_SIZE + pos.
REQ-016 plane_rdy  out  1  one-cycle pulse; last neuron of a plane written.
REQ-017 busy  out  1  high in any state except IDLE.
REQ-018 done  out  1  one-cycle pulse; last neuron of last plane written.

Function
REQ-019 FSM states IDLE, ACCUM, WRITE; IDLE->ACCUM on start; ACCUM->WRITE on last tap; WRITE->ACCUM on accept unless final; WRITE->IDLE on final accept.
REQ-020 Tap handshake: tap consumed when mac_en&&mac_valid; tap_cnt counts 0..N_TAPS-1; mac_valid=0 holds tap_cnt (stall, no timeout).
REQ-021 acc_clr = mac_en && mac_valid && tap_cnt==0 (combinational, same cycle as the first tap).
REQ-022 Last tap consumed: tap_cnt->0, neuron_rdy=1 next cycle, state->WRITE next cycle; N_TAPS=1 makes every tap both first and last.
REQ-023 WRITE: wr_en=1, wr_addr stable until wr_ready=1; write accepted when wr_en&&wr_ready; wr_ready outside WRITE ignored.
REQ-024 On accept: pos increments; at pos==PLANE_SIZE-1, pos->0, plane_base += PLANE_SIZE (adder, no multiplier), plane_cnt++, plane_rdy pulses next cycle.
REQ-025 On accept of pos==PLANE_SIZE-1 with plane_cnt==N_PLANES-1: plane_rdy and done pulse together next cycle, state->IDLE, all counters->0.
REQ-026 wr_addr = plane_base + pos, registered; first write 0, last write N_PLANES*PLANE_SIZE-1; no wrap within a pass.
REQ-027 abort has priority over every other event same cycle: next cycle state IDLE, counters 0, wr_en 0, no done/plane_rdy/neuron_rdy pulse.
REQ-028 start and abort together in IDLE: abort wins, stays IDLE.
REQ-029 start in the same cycle as done's transition to IDLE is ignored; new pass needs start with busy=0.
REQ-030 Latency: start at cycle t -> mac_en=1 at t+1.

Reset
REQ-031 rst_n=0 asynchronously forces IDLE, tap_cnt/pos/plane_cnt/plane_base=0, and all outputs 0 (wr_addr=0).
REQ-032 Reset mid-pass discards progress; after release, nothing happens until a new start.

Structure
REQ-033 Shared package cnn_ctrl_pkg holds the FSM state enumeration and default constants (N_TAPS=25, PLANE_SIZE=196, N_PLANES=6, AW=16).
REQ-034 One sub-module, wrap_cnt (parameterised terminal-count counter with enable, clear, terminal flag), instantiated for the tap, pos and plane counters.

Verification
REQ-035 Defaults, mac_valid=1, wr_ready=1 always -> 1176 writes, addresses 0..1175 in order, 6 plane_rdy pulses, 1 done, neuron_rdy every 26 cycles.
REQ-036 N_TAPS=3, mac_valid pattern 1,0,0,1,1 -> acc_clr only on the 1st tap, neuron_rdy one cycle after the 5th cycle, tap_cnt held during gaps.
REQ-037 wr_ready low 4 cycles in WRITE at pos 7 -> wr_en and wr_addr=7 held stable 5 cycles, mac_en=0 throughout, single write.
REQ-038 PLANE_SIZE=4, N_PLANES=2, N_TAPS=1 -> addresses 0..7, plane_rdy after writes 3 and 7, done coincident with the 2nd plane_rdy, busy=0 after.
REQ-039 abort during WRITE at address 100, then start -> wr_en drops next cycle, no done; new pass restarts at address 0.
REQ-040 rst_n asserted mid-ACCUM between clock edges -> outputs 0 immediately; start ignored during reset; pass from address 0 after release and start.

Source files
------------

// File: rtl/cnn_ctrl_pkg.sv
// rtl/cnn_ctrl_pkg.sv - shared FSM encoding and default geometry for the conv output sequencer
package cnn_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_WRITE = 2'd2
    } seq_state_t;

    localparam int DEF_N_TAPS     = 25;
    localparam int DEF_PLANE_SIZE = 196;
    localparam int DEF_N_PLANES   = 6;
    localparam int DEF_AW         = 16;

endpackage

// File: rtl/wrap_cnt.sv
// rtl/wrap_cnt.sv - terminal-count counter with enable, synchronous clear and terminal flag
module wrap_cnt #(
    parameter int W   = 8,
    parameter int MAX = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign at_max = (cnt == MAX_V);

    // count 0..MAX, wrapping to 0 on the enabled cycle at MAX; clear wins over enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_max ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/conv_out_seq.sv
// rtl/conv_out_seq.sv - sequences MAC taps per neuron and writes neurons plane by plane
module conv_out_seq
    import cnn_ctrl_pkg::*;
#(
    parameter int N_TAPS     = DEF_N_TAPS,
    parameter int PLANE_SIZE = DEF_PLANE_SIZE,
    parameter int N_PLANES   = DEF_N_PLANES,
    parameter int AW         = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          mac_valid,
    input  logic          wr_ready,
    output logic          mac_en,
    output logic          acc_clr,
    output logic          neuron_rdy,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          plane_rdy,
    output logic          busy,
    output logic          done
);

    localparam longint TOTAL_WORDS = longint'(N_PLANES) * longint'(PLANE_SIZE);
    localparam longint ADDR_SPAN   = longint'(1) << AW;
    localparam logic [AW-1:0] PLANE_STEP = AW'(PLANE_SIZE);

    // refuse to build a layer that cannot be addressed without wrapping
    generate
        if (TOTAL_WORDS > ADDR_SPAN || N_TAPS < 1 || N_TAPS > 255 ||
            PLANE_SIZE < 1 || PLANE_SIZE > 65535 || N_PLANES < 1 || N_PLANES > 255) begin : g_bad_cfg
            $error("conv_out_seq: illegal geometry for the given address width");
        end
    endgenerate

    seq_state_t    state, state_nxt;
    logic [7:0]    tap_cnt;
    logic [15:0]   pos_cnt;
    logic [7:0]    plane_cnt;
    logic          tap_at_max, pos_at_max, plane_at_max;
    logic [AW-1:0] plane_base;
    logic          tap_fire, last_tap, wr_fire, plane_end, final_wr;
    logic          unused_plane_cnt;

    assign tap_fire  = mac_en && mac_valid;
    assign last_tap  = tap_fire && tap_at_max;
    assign wr_fire   = wr_en && wr_ready;
    assign plane_end = wr_fire && pos_at_max;
    assign final_wr  = plane_end && plane_at_max;

    // plane index itself is only observed through its terminal flag
    assign unused_plane_cnt = ^plane_cnt;

    wrap_cnt #(.W(8), .MAX(N_TAPS - 1)) u_tap_cnt (
        .clk(clk), .rst_n(rst_n), .clr(abort), .en(tap_fire),
        .cnt(tap_cnt), .at_max(tap_at_max)
    );

    wrap_cnt #(.W(16), .MAX(PLANE_SIZE - 1)) u_pos_cnt (
        .clk(clk), .rst_n(rst_n), .clr(abort), .en(wr_fire),
        .cnt(pos_cnt), .at_max(pos_at_max)
    );

    wrap_cnt #(.W(8), .MAX(N_PLANES - 1)) u_plane_cnt (
        .clk(clk), .rst_n(rst_n), .clr(abort), .en(plane_end),
        .cnt(plane_cnt), .at_max(plane_at_max)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state: abort overrides everything, final accept returns to idle
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start)    state_nxt = ST_ACCUM;
                ST_ACCUM: if (last_tap) state_nxt = ST_WRITE;
                ST_WRITE: if (wr_fire)  state_nxt = final_wr ? ST_IDLE : ST_ACCUM;
                default:                state_nxt = ST_IDLE;
            endcase
        end
    end

    // state-decoded handshakes; acc_clr rides on the first tap of each neuron
    always_comb begin
        mac_en  = (state == ST_ACCUM);
        wr_en   = (state == ST_WRITE);
        busy    = (state != ST_IDLE);
        acc_clr = mac_en && mac_valid && (tap_cnt == '0);
    end

    // plane base advances by addition so no multiplier is needed for the address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            plane_base <= '0;
        end else if (abort || final_wr) begin
            plane_base <= '0;
        end else if (plane_end) begin
            plane_base <= plane_base + PLANE_STEP;
        end
    end

    // registered write address tracks plane_base + pos for the upcoming write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
        end else if (abort) begin
            wr_addr <= '0;
        end else if (wr_fire) begin
            if (final_wr) begin
                wr_addr <= '0;
            end else if (pos_at_max) begin
                wr_addr <= plane_base + PLANE_STEP;
            end else begin
                wr_addr <= plane_base + AW'(pos_cnt) + AW'(1);
            end
        end
    end

    // one-cycle status pulses following the triggering event, suppressed by abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neuron_rdy <= 1'b0;
            plane_rdy  <= 1'b0;
            done       <= 1'b0;
        end else begin
            neuron_rdy <= last_tap && !abort;
            plane_rdy  <= plane_end && !abort;
            done       <= final_wr && !abort;
        end
    end

endmodule

// File: tb/tb_conv_out_seq.sv
// tb/tb_conv_out_seq.sv - scoreboard bench for conv_out_seq across three geometries
module tb_conv_out_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // default geometry instance
    logic d_start = 0, d_abort = 0, d_mac_valid = 0, d_wr_ready = 0;
    logic d_mac_en, d_acc_clr, d_neuron_rdy, d_wr_en, d_plane_rdy, d_busy, d_done;
    logic [15:0] d_wr_addr;
    // N_TAPS=3 small-plane instance
    logic b_start = 0, b_abort = 0, b_mac_valid = 0, b_wr_ready = 0;
    logic b_mac_en, b_acc_clr, b_neuron_rdy, b_wr_en, b_plane_rdy, b_busy, b_done;
    logic [15:0] b_wr_addr;
    // N_TAPS=1 small-plane instance
    logic c_start = 0, c_abort = 0, c_mac_valid = 0, c_wr_ready = 0;
    logic c_mac_en, c_acc_clr, c_neuron_rdy, c_wr_en, c_plane_rdy, c_busy, c_done;
    logic [15:0] c_wr_addr;

    conv_out_seq dut (
        .clk(clk), .rst_n(rst_n), .start(d_start), .abort(d_abort),
        .mac_valid(d_mac_valid), .wr_ready(d_wr_ready), .mac_en(d_mac_en),
        .acc_clr(d_acc_clr), .neuron_rdy(d_neuron_rdy), .wr_en(d_wr_en),
        .wr_addr(d_wr_addr), .plane_rdy(d_plane_rdy), .busy(d_busy), .done(d_done)
    );

    conv_out_seq #(.N_TAPS(3), .PLANE_SIZE(4), .N_PLANES(2), .AW(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
        .mac_valid(b_mac_valid), .wr_ready(b_wr_ready), .mac_en(b_mac_en),
        .acc_clr(b_acc_clr), .neuron_rdy(b_neuron_rdy), .wr_en(b_wr_en),
        .wr_addr(b_wr_addr), .plane_rdy(b_plane_rdy), .busy(b_busy), .done(b_done)
    );

    conv_out_seq #(.N_TAPS(1), .PLANE_SIZE(4), .N_PLANES(2), .AW(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .abort(c_abort),
        .mac_valid(c_mac_valid), .wr_ready(c_wr_ready), .mac_en(c_mac_en),
        .acc_clr(c_acc_clr), .neuron_rdy(c_neuron_rdy), .wr_en(c_wr_en),
        .wr_addr(c_wr_addr), .plane_rdy(c_plane_rdy), .busy(c_busy), .done(c_done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int exp_addr, n_wr, n_plane, n_done, n_clr, n_nr, n7, hold, last_nr, prev_acc;
    bit fin;
    int pat[5]     = '{1, 0, 0, 1, 1};
    int clr_exp[5] = '{1, 0, 0, 0, 0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_q(input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(i);
    endtask

    task automatic pop_check(input string tag, input logic [15:0] got);
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected_write"}, got, 64'hFFFF_FFFF);
            exp_addr = -1;
        end else begin
            exp_addr = exp_q.pop_front();
            check(tag, got, exp_addr);
        end
    endtask

    initial begin
        // reset state, sampled while reset is held
        #3;
        check("rst_busy", d_busy, 0);
        check("rst_wr_en", d_wr_en, 0);
        check("rst_wr_addr", d_wr_addr, 0);
        check("rst_mac_en", d_mac_en, 0);
        check("rst_done", d_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // full default pass with both sides always ready
        fill_q(1176);
        d_mac_valid = 1; d_wr_ready = 1;
        n_wr = 0; n_plane = 0; n_done = 0; last_nr = -1; fin = 0;
        @(posedge clk); #1; d_start = 1;
        @(negedge clk);
        check("d_busy_start_cycle", d_busy, 0);
        for (int cyc = 0; cyc < 40000 && !fin; cyc++) begin
            @(posedge clk); #1; d_start = 0;
            @(negedge clk);
            if (cyc == 0) check("d_latency_mac_en", d_mac_en, 1);
            if (d_neuron_rdy) begin
                if (last_nr >= 0) check("d_neuron_period", cyc - last_nr, 26);
                last_nr = cyc;
            end
            if (d_plane_rdy) n_plane++;
            if (d_done) begin
                n_done++;
                check("d_done_with_plane_rdy", d_plane_rdy, 1);
                check("d_busy_at_done", d_busy, 0);
                fin = 1;
            end
            if (d_wr_en && d_wr_ready) begin pop_check("d_wr_addr", d_wr_addr); n_wr++; end
        end
        check("d_pass_finished", fin, 1);
        check("d_write_count", n_wr, 1176);
        check("d_plane_rdy_count", n_plane, 6);
        check("d_done_count", n_done, 1);
        check("d_queue_drained", exp_q.size(), 0);

        // back-pressure at address 7, then abort while writing address 100
        fill_q(1176);
        n_wr = 0; n7 = 0; hold = 0; fin = 0;
        @(posedge clk); #1; d_start = 1;
        @(negedge clk);
        for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
            @(posedge clk); #1;
            d_start = 0; d_wr_ready = 1; d_abort = 0;
            if (d_wr_en && d_wr_addr == 16'd7 && hold < 4) begin d_wr_ready = 0; hold++; end
            if (d_wr_en && d_wr_addr == 16'd100) d_abort = 1;
            @(negedge clk);
            if (d_wr_en && d_wr_addr == 16'd7) begin
                n7++;
                check("hold_mac_en", d_mac_en, 0);
            end
            if (d_abort) fin = 1;
            else if (d_wr_en && d_wr_ready) begin pop_check("bp_wr_addr", d_wr_addr); n_wr++; end
        end
        check("abort_reached", fin, 1);
        check("hold_cycles_at_7", n7, 5);
        check("writes_before_abort", n_wr, 100);
        @(posedge clk); #1; d_abort = 0;
        @(negedge clk);
        check("abort_wr_en", d_wr_en, 0);
        check("abort_busy", d_busy, 0);
        check("abort_done", d_done, 0);
        check("abort_plane_rdy", d_plane_rdy, 0);
        check("abort_neuron_rdy", d_neuron_rdy, 0);
        check("abort_wr_addr", d_wr_addr, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_after_abort", d_busy, 0);
        end

        // restart from 0, then reset asynchronously in the middle of ACCUM
        fill_q(1176);
        n_wr = 0;
        @(posedge clk); #1; d_start = 1;
        @(negedge clk);
        for (int cyc = 0; cyc < 500 && n_wr < 3; cyc++) begin
            @(posedge clk); #1; d_start = 0;
            @(negedge clk);
            if (d_wr_en && d_wr_ready) begin pop_check("restart_wr_addr", d_wr_addr); n_wr++; end
        end
        check("restart_writes", n_wr, 3);
        repeat (5) @(negedge clk);
        check("mid_accum", d_mac_en, 1);
        #2; rst_n = 0; d_start = 1;
        #1;
        check("async_rst_mac_en", d_mac_en, 0);
        check("async_rst_busy", d_busy, 0);
        check("async_rst_wr_addr", d_wr_addr, 0);
        check("async_rst_wr_en", d_wr_en, 0);
        repeat (2) @(negedge clk);
        check("start_in_reset", d_busy, 0);
        rst_n = 1; d_start = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_after_reset", d_busy, 0);
        end
        fill_q(1176);
        n_wr = 0;
        @(posedge clk); #1; d_start = 1;
        @(negedge clk);
        for (int cyc = 0; cyc < 200 && n_wr < 1; cyc++) begin
            @(posedge clk); #1; d_start = 0;
            @(negedge clk);
            if (d_wr_en && d_wr_ready) begin pop_check("post_reset_wr_addr", d_wr_addr); n_wr++; end
        end
        check("post_reset_write", n_wr, 1);
        @(posedge clk); #1; d_abort = 1;
        @(posedge clk); #1; d_abort = 0;
        @(negedge clk);
        check("final_abort_idle", d_busy, 0);

        // N_TAPS=3 with stalled taps
        fill_q(8);
        b_wr_ready = 1; b_mac_valid = 0; n_wr = 0; n_plane = 0; fin = 0;
        @(posedge clk); #1; b_start = 1;
        @(negedge clk);
        check("b_idle_start_cycle", b_busy, 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            b_start = 0;
            b_mac_valid = (i < 5) ? pat[i][0] : 1'b1;
            @(negedge clk);
            if (i < 5) begin
                check("b_mac_en", b_mac_en, 1);
                check("b_acc_clr", b_acc_clr, clr_exp[i]);
                check("b_neuron_rdy_early", b_neuron_rdy, 0);
            end else begin
                check("b_neuron_rdy", b_neuron_rdy, 1);
                check("b_wr_en", b_wr_en, 1);
                check("b_acc_clr_in_write", b_acc_clr, 0);
                pop_check("b_wr_addr", b_wr_addr);
                n_wr++;
            end
        end
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (b_plane_rdy) n_plane++;
            if (b_done) fin = 1;
            if (b_wr_en && b_wr_ready) begin pop_check("b_wr_addr", b_wr_addr); n_wr++; end
        end
        check("b_done_seen", fin, 1);
        check("b_write_count", n_wr, 8);
        check("b_plane_count", n_plane, 2);

        // N_TAPS=1, two planes of four; start offered on the final accept
        fill_q(8);
        c_mac_valid = 1; c_wr_ready = 1;
        n_wr = 0; n_clr = 0; n_nr = 0; fin = 0; prev_acc = -1;
        @(posedge clk); #1; c_start = 1;
        @(negedge clk);
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            @(posedge clk); #1;
            c_start = (c_wr_en && c_wr_addr == 16'd7);
            @(negedge clk);
            check("c_plane_rdy", c_plane_rdy, (prev_acc == 3 || prev_acc == 7));
            check("c_done", c_done, (prev_acc == 7));
            if (c_acc_clr) n_clr++;
            if (c_neuron_rdy) n_nr++;
            if (c_done) begin
                fin = 1;
                check("c_busy_at_done", c_busy, 0);
            end
            prev_acc = -1;
            if (c_wr_en && c_wr_ready) begin
                pop_check("c_wr_addr", c_wr_addr);
                prev_acc = exp_addr;
                n_wr++;
            end
        end
        check("c_done_seen", fin, 1);
        check("c_write_count", n_wr, 8);
        check("c_acc_clr_count", n_clr, 8);
        check("c_neuron_rdy_count", n_nr, 8);
        @(posedge clk); #1; c_start = 0;
        @(negedge clk);
        check("c_start_at_done_ignored", c_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
